// File: rtl/hc595_ctrl.sv
// Serial driver for two cascaded 74HC595 shift registers.
// Sends the 16-bit frame {seg, sel} MSB first whenever the inputs change
// (or once after reset), then pulses the storage latch.
module hc595_ctrl #(
  parameter int unsigned DIV = 24
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] seg,
  input  logic [7:0] sel,
  output logic       ds,
  output logic       shcp,
  output logic       stcp,
  output logic       oe_n,
  output logic       busy
);

  localparam int unsigned FRAME_W = 16;
  localparam int unsigned CNT_W   = 4;
  localparam int unsigned DIV_W   = 8;

  localparam logic [DIV_W-1:0] DIV_MAX  = DIV_W'(DIV);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_W - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LATCH = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [FRAME_W-1:0]   shreg_q, shreg_d;
  logic [FRAME_W-1:0]   frame_q, frame_d;
  logic [FRAME_W-1:0]   last_q,  last_d;
  logic [DIV_W-1:0]     div_q,   div_d;
  logic [CNT_W-1:0]     cnt_q,   cnt_d;
  logic                 phase_q, phase_d;
  logic                 force_q, force_d;
  logic                 ds_q,    ds_d;
  logic                 shcp_q,  shcp_d;
  logic                 stcp_q,  stcp_d;
  logic                 oe_n_q,  oe_n_d;
  logic                 busy_q,  busy_d;

  logic [FRAME_W-1:0]   frame_in_c;
  logic                 tick_c;

  assign frame_in_c = {seg, sel};
  assign tick_c     = (state_q != IDLE) && (div_q == DIV_MAX);

  // Next-state and next-output logic; every register holds unless a tick or start acts on it.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    frame_d = frame_q;
    last_d  = last_q;
    div_d   = div_q;
    cnt_d   = cnt_q;
    phase_d = phase_q;
    force_d = force_q;
    ds_d    = ds_q;
    shcp_d  = shcp_q;
    stcp_d  = stcp_q;
    oe_n_d  = oe_n_q;
    busy_d  = busy_q;

    if (state_q != IDLE) begin
      div_d = tick_c ? '0 : DIV_W'(div_q + DIV_W'(1));
    end

    unique case (state_q)
      IDLE: begin
        // Start when the pattern changed since the last latch, or on the first frame after reset.
        if ((frame_in_c != last_q) || force_q) begin
          shreg_d = frame_in_c;
          frame_d = frame_in_c;
          div_d   = '0;
          cnt_d   = '0;
          phase_d = 1'b0;
          force_d = 1'b0;
          busy_d  = 1'b1;
          state_d = SHIFT;
        end
      end

      SHIFT: begin
        if (tick_c) begin
          if (!phase_q) begin
            // Tick A: present the next bit with the shift clock low.
            ds_d    = shreg_q[FRAME_W-1];
            shcp_d  = 1'b0;
            phase_d = 1'b1;
          end else begin
            // Tick B: rising shift clock, then advance to the next bit.
            shcp_d  = 1'b1;
            shreg_d = {shreg_q[FRAME_W-2:0], 1'b0};
            cnt_d   = CNT_W'(cnt_q + CNT_W'(1));
            phase_d = 1'b0;
            if (cnt_q == LAST_BIT) begin
              state_d = LATCH;
            end
          end
        end
      end

      LATCH: begin
        if (tick_c) begin
          if (!phase_q) begin
            // Drop the shift clock in the same tick the latch clock rises, never overlapping.
            shcp_d  = 1'b0;
            stcp_d  = 1'b1;
            phase_d = 1'b1;
          end else begin
            stcp_d  = 1'b0;
            last_d  = frame_q;
            oe_n_d  = 1'b0;
            busy_d  = 1'b0;
            phase_d = 1'b0;
            state_d = IDLE;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any transfer in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shreg_q <= '0;
      frame_q <= '0;
      last_q  <= '0;
      div_q   <= '0;
      cnt_q   <= '0;
      phase_q <= 1'b0;
      force_q <= 1'b1;
      ds_q    <= 1'b0;
      shcp_q  <= 1'b0;
      stcp_q  <= 1'b0;
      oe_n_q  <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      frame_q <= frame_d;
      last_q  <= last_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      force_q <= force_d;
      ds_q    <= ds_d;
      shcp_q  <= shcp_d;
      stcp_q  <= stcp_d;
      oe_n_q  <= oe_n_d;
      busy_q  <= busy_d;
    end
  end

  assign ds   = ds_q;
  assign shcp = shcp_q;
  assign stcp = stcp_q;
  assign oe_n = oe_n_q;
  assign busy = busy_q;

endmodule
